// File: rtl/xorshift8_stream_checker_if.sv
// xorshift8_stream_checker_if: sample stream in, lock/error status out.
// The master drives the samples; the checker sits on the slave side.
interface xorshift8_stream_checker_if #(parameter int CNT_W = 8);
    logic [7:0]       din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       expected;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err_pulse, err_count, expected
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err_pulse, err_count, expected
    );
endinterface

// File: rtl/xorshift8_stream_checker.sv
// xorshift8_stream_checker: locks onto an 8-bit xorshift stream, then flywheels its own
// predictor and counts mismatches until enough consecutive misses drop the lock.
module xorshift8_stream_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic rst_n,
    xorshift8_stream_checker_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    function automatic logic [7:0] f(input logic [7:0] x);
        logic [7:0] a;
        logic [7:0] b;
        a = x ^ (x << 3);
        b = a ^ (a >> 5);
        return b ^ (b << 4);
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       seed_q, seed_d;
    logic             seed_valid_q, seed_valid_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [3:0]       bad_cnt_q, bad_cnt_d;
    logic [7:0]       expected_q, expected_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             hunt_match, lock_match, err_inc;

    // Zero is a fixed point of f, so it can neither seed nor confirm a lock.
    assign hunt_match = seed_valid_q && bus.din == f(seed_q) && bus.din != 8'h00;
    assign lock_match = bus.din == expected_q;

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        seed_valid_d = seed_valid_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        expected_d   = expected_q;
        err_pulse_d  = 1'b0;
        err_inc      = 1'b0;
        if (bus.din_valid) begin
            if (state_q == HUNT) begin
                seed_d       = bus.din;
                seed_valid_d = |bus.din;
                good_cnt_d   = hunt_match ? good_cnt_q + 4'd1 : 4'd0;
                if (hunt_match && good_cnt_q + 4'd1 == LOCK_N) begin
                    state_d    = LOCKED;
                    expected_d = f(bus.din);
                    bad_cnt_d  = 4'd0;
                    good_cnt_d = 4'd0;
                end
            end else begin
                // Flywheel: the predictor advances on every sample and never resyncs to din.
                expected_d  = f(expected_q);
                err_pulse_d = !lock_match;
                err_inc     = !lock_match;
                bad_cnt_d   = lock_match ? 4'd0 : bad_cnt_q + 4'd1;
                if (!lock_match && bad_cnt_q + 4'd1 == LOSS_N) begin
                    state_d      = HUNT;
                    good_cnt_d   = 4'd0;
                    seed_d       = bus.din;
                    seed_valid_d = |bus.din;
                end
            end
        end
        err_count_d = bus.clr_cnt ? '0 :
                      (err_inc && err_count_q != '1) ? err_count_q + CNT_W'(1) : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            seed_q       <= 8'h00;
            seed_valid_q <= 1'b0;
            good_cnt_q   <= 4'd0;
            bad_cnt_q    <= 4'd0;
            expected_q   <= 8'h00;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            seed_valid_q <= seed_valid_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            expected_q   <= expected_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.locked    = state_q == LOCKED;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.expected  = expected_q;
endmodule
